// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports (port 1 wins),
// per-register busy scoreboard and a registered same-address write-collision pulse.
// Optional build macro: REGFILE_BYPASS_EN adds a same-cycle write-to-read forwarding path.
module register_file_mp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     wr_collision
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                coll_q, coll_d;
    logic                we0, we1, sbv;

    // Writable/readable: inside the array and not the hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        we0    = wr_en0 && !reset && addr_ok(wr_addr0);
        we1    = wr_en1 && !reset && addr_ok(wr_addr1);
        sbv    = sb_set && !reset && addr_ok(sb_addr);
        regs_d = regs_q;
        busy_d = busy_q;
        if (we0) begin
            regs_d[wr_addr0] = wr_data0;
            busy_d[wr_addr0] = 1'b0;
        end
        if (we1) begin
            regs_d[wr_addr1] = wr_data1;
            busy_d[wr_addr1] = 1'b0;
        end
        // A new reservation supersedes a completing write to the same register.
        if (sbv) begin
            busy_d[sb_addr] = 1'b1;
        end
        coll_d = wr_en0 && wr_en1 && (wr_addr0 == wr_addr1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            coll_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            coll_q <= coll_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] d;
            logic              b;
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            d  = '0;
            b  = 1'b0;
            if (addr_ok(ra)) begin
                d = regs_q[ra];
                b = busy_q[ra];
            end
`ifdef REGFILE_BYPASS_EN
            if (we1 && (wr_addr1 == ra)) begin
                d = wr_data1;
                b = sbv && (sb_addr == ra);
            end else if (we0 && (wr_addr0 == ra)) begin
                d = wr_data0;
                b = sbv && (sb_addr == ra);
            end
`endif
            rd_data[i*DATA_W +: DATA_W] = d;
            rd_busy[i]                  = b;
        end
    end

    assign busy         = busy_q;
    assign wr_collision = coll_q;

endmodule
